vram_oam_arbiter: RTL and testbench
===================================

Name: vram_oam_arbiter

Overview:
Shares the single-port VRAM (8 KiB) and OAM (160 B) arrays between the CPU bus, the pixel processing unit and the OAM DMA engine. Ownership follows the PPU mode (HBlank/VBlank/OAMScan/Draw): CPU accesses to a locked region are masked, as on the real LR35902 system. Contains the OAM DMA sequencer. Sits between the CPU memory decoder, the PPU fetcher/OAM scanner and the VRAM/OAM BRAMs.

Parameters:
DMA_PERIOD, 4, clock cycles per DMA byte (one M-cycle).
OAM_BYTES, 160, number of bytes copied per DMA.

Ports:
clk_in  input  1  system clock (T-cycle)
rst_in  input  1  synchronous active-high reset
ppu_mode_in  input  2  0=HBlank, 1=VBlank, 2=OAMScan, 3=Draw
lcd_en_in  input  1  LCDC.7; 0 means the CPU owns everything
cpu_req_in  input  1  one-cycle access strobe
cpu_we_in  input  1  1=write
cpu_addr_in  input  16  CPU address
cpu_wdata_in  input  8  write data
cpu_rdata_out  output  8  read data, valid with ack
cpu_ack_out  output  1  one-cycle completion pulse
ppu_vram_req_in  input  1  PPU VRAM read strobe
ppu_vram_addr_in  input  13  VRAM offset
ppu_vram_data_out  output  8  read data
ppu_vram_valid_out  output  1  read data valid
ppu_oam_req_in  input  1  PPU OAM read strobe
ppu_oam_addr_in  input  8  OAM offset
ppu_oam_data_out  output  8  read data
ppu_oam_valid_out  output  1  read data valid
dma_start_in  input  1  FF46 write strobe
dma_src_in  input  8  FF46 value (source high byte)
dma_active_out  output  1  DMA in progress
dma_rd_req_out  output  1  source read strobe
dma_rd_addr_out  output  16  source address
dma_rd_data_in  input  8  source data, 1 cycle after req
vram_addr_out  output  13  / vram_we_out  output 1 / vram_wdata_out output 8 / vram_rdata_in input 8 (1-cycle sync read)
oam_addr_out  output  8  / oam_we_out  output 1 / oam_wdata_out output 8 / oam_rdata_in input 8 (1-cycle sync read)

Behaviour:
- Reset: all outputs 0, DMA idle, no CPU access outstanding. Reset during DMA aborts it, and no further OAM writes occur.
- Regions: VRAM = 0x8000–0x9FFF (offset = addr[12:0]). OAM = 0xFE00–0xFE9F (offset = addr[7:0]). Other addresses: no array access; ack with 0xFF.
- Locks apply only when lcd_en_in=1:
  - VRAM is locked in Draw.
  - OAM is locked in OAMScan and Draw.
  - OAM is locked whenever DMA is active, independent of lcd_en_in.
- The lock decision is sampled on the cycle cpu_req_in is accepted.
- CPU access:
  - Accepted when no access is outstanding. A req during an outstanding access is ignored.
  - cpu_ack_out pulses exactly 2 cycles after acceptance (cycle 0: drive array; cycle 1: array data; cycle 2: ack + rdata).
  - Locked reads return 0xFF. Locked writes are dropped but still acked.
- PPU ports:
  - Served only in owning modes: VRAM in Draw; OAM in OAMScan/Draw.
  - With lcd_en_in=0, PPU requests are ignored.
  - valid pulses 1 cycle after req. Requests outside owning modes produce no valid.
  - The CPU never gets an array slot while the PPU owns it, so there is no contention.
- DMA FSM states: IDLE, READ, WRITE, WAIT.
  - dma_start_in latches src. dma_active_out=1 from the next cycle.
  - Byte k: READ issues dma_rd_req_out with address {src,8'h00}+k. Next cycle (WRITE) sets oam_we_out=1, oam_addr_out=k, oam_wdata_out=dma_rd_data_in. WAIT fills to DMA_PERIOD cycles per byte.
  - After byte OAM_BYTES-1, return to IDLE and drop dma_active_out. Total time is 640 cycles.
  - src ≥ 0xE0 maps to src−0x20 (echo RAM).
  - dma_start_in while active restarts at k=0 with the new src.
  - A DMA write cycle preempts a PPU OAM read in the same cycle: that request gets no valid.
- Arithmetic: k is a 8-bit counter, 0..159. The source address is 16-bit with no carry into the high byte.

Test Plan:
- Mode=HBlank, lcd_en=1: CPU write 0x8123←0x5A, then read 0x8123 → ack 2 cycles after each req, rdata 0x5A.
- Mode=Draw: CPU read 0x8123 → rdata 0xFF. CPU write 0x8000←0x11 is dropped; a later HBlank read of 0x8000 returns the old value. PPU VRAM read 0x0123 → valid next cycle with 0x5A.
- Mode=OAMScan: CPU read 0xFE10 → 0xFF. Set lcd_en=0 and repeat → real data; PPU OAM req yields no valid.
- dma_start with src=0xC1 and source byte k = k^0xA5 → dma_active high for 640 cycles, OAM[k]=k^0xA5 for k=0..159, last write at addr 159. CPU OAM read during DMA → 0xFF.
- Restart DMA at byte 50 with src=0xE2 → reads restart at 0xC200, 160 more writes. Reset at byte 30 → dma_active_out=0 next cycle, no further oam_we_out.
- CPU read 0xFF80 → ack after 2 cycles, rdata 0xFF, no vram/oam strobes. Second req while outstanding → exactly one ack.

Source files
------------

// File: rtl/vram_oam_arbiter_if.sv
// Bus bundle between the VRAM/OAM arbiter and its neighbours: CPU decoder, PPU
// fetcher/OAM scanner, OAM DMA source port and the two single-port BRAMs.
interface vram_oam_arbiter_if;
  logic [1:0]  ppu_mode_in;
  logic        lcd_en_in;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_ack_out;
  logic        ppu_vram_req_in;
  logic [12:0] ppu_vram_addr_in;
  logic [7:0]  ppu_vram_data_out;
  logic        ppu_vram_valid_out;
  logic        ppu_oam_req_in;
  logic [7:0]  ppu_oam_addr_in;
  logic [7:0]  ppu_oam_data_out;
  logic        ppu_oam_valid_out;
  logic        dma_start_in;
  logic [7:0]  dma_src_in;
  logic        dma_active_out;
  logic        dma_rd_req_out;
  logic [15:0] dma_rd_addr_out;
  logic [7:0]  dma_rd_data_in;
  logic [12:0] vram_addr_out;
  logic        vram_we_out;
  logic [7:0]  vram_wdata_out;
  logic [7:0]  vram_rdata_in;
  logic [7:0]  oam_addr_out;
  logic        oam_we_out;
  logic [7:0]  oam_wdata_out;
  logic [7:0]  oam_rdata_in;

  modport slave (
    input  ppu_mode_in, lcd_en_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
           ppu_vram_req_in, ppu_vram_addr_in, ppu_oam_req_in, ppu_oam_addr_in,
           dma_start_in, dma_src_in, dma_rd_data_in, vram_rdata_in, oam_rdata_in,
    output cpu_rdata_out, cpu_ack_out, ppu_vram_data_out, ppu_vram_valid_out,
           ppu_oam_data_out, ppu_oam_valid_out, dma_active_out, dma_rd_req_out,
           dma_rd_addr_out, vram_addr_out, vram_we_out, vram_wdata_out,
           oam_addr_out, oam_we_out, oam_wdata_out
  );

  modport master (
    output ppu_mode_in, lcd_en_in, cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
           ppu_vram_req_in, ppu_vram_addr_in, ppu_oam_req_in, ppu_oam_addr_in,
           dma_start_in, dma_src_in, dma_rd_data_in, vram_rdata_in, oam_rdata_in,
    input  cpu_rdata_out, cpu_ack_out, ppu_vram_data_out, ppu_vram_valid_out,
           ppu_oam_data_out, ppu_oam_valid_out, dma_active_out, dma_rd_req_out,
           dma_rd_addr_out, vram_addr_out, vram_we_out, vram_wdata_out,
           oam_addr_out, oam_we_out, oam_wdata_out
  );
endinterface

// File: rtl/vram_oam_arbiter.sv
// Mode-driven ownership of VRAM/OAM between CPU, PPU and OAM DMA, plus the OAM
// DMA sequencer. CPU accesses complete with a fixed 2-cycle ack latency.
module vram_oam_arbiter #(
  parameter int DMA_PERIOD = 4,
  parameter int OAM_BYTES  = 160
) (
  input logic               clk_in,
  input logic               rst_in,
  vram_oam_arbiter_if.slave bus
);
  typedef enum logic [1:0] {DMA_IDLE, DMA_READ, DMA_WRITE, DMA_WAIT} dma_state_e;
  typedef enum logic [1:0] {SEL_FF, SEL_VRAM, SEL_OAM} cpu_sel_e;

  dma_state_e  dma_state_q;
  logic        dma_active_q, dma_rd_req_q;
  logic [15:0] dma_rd_addr_q;
  logic [7:0]  dma_src_q, dma_k_q, dma_wait_q;
  logic        vld_p1_q, cpu_ack_q;
  cpu_sel_e    sel_p1_q, cpu_sel_d;
  logic [7:0]  cpu_rdata_q;
  logic        ppu_vram_vld_q, ppu_oam_vld_q;

  logic cpu_accept, cpu_is_vram, cpu_is_oam, vram_lock, oam_lock;
  logic ppu_vram_own, ppu_oam_own, ppu_vram_go, ppu_oam_go;
  logic cpu_vram_go, cpu_oam_go, dma_wr;

  function automatic logic [7:0] echo_map(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

  function automatic logic [7:0] cpu_read_mux(input cpu_sel_e sel, input logic [7:0] v,
                                              input logic [7:0] o);
    case (sel)
      SEL_VRAM: return v;
      SEL_OAM:  return o;
      default:  return 8'hFF;
    endcase
  endfunction

  // PPU ownership is exactly the CPU lock window, so the two never share an array slot.
  assign ppu_vram_own = bus.lcd_en_in && (bus.ppu_mode_in == 2'd3);
  assign ppu_oam_own  = bus.lcd_en_in && bus.ppu_mode_in[1];
  assign vram_lock    = ppu_vram_own;
  assign oam_lock     = ppu_oam_own || dma_active_q;
  assign dma_wr       = (dma_state_q == DMA_WRITE);

  assign cpu_is_vram  = (bus.cpu_addr_in[15:13] == 3'b100);
  assign cpu_is_oam   = (bus.cpu_addr_in[15:8] == 8'hFE) && (bus.cpu_addr_in[7:0] < 8'hA0);
  assign cpu_accept   = bus.cpu_req_in && !vld_p1_q && !cpu_ack_q;
  assign cpu_vram_go  = cpu_accept && cpu_is_vram && !vram_lock;
  assign cpu_oam_go   = cpu_accept && cpu_is_oam && !oam_lock;
  assign ppu_vram_go  = bus.ppu_vram_req_in && ppu_vram_own;
  assign ppu_oam_go   = bus.ppu_oam_req_in && ppu_oam_own && !dma_wr;

  always_comb begin
    cpu_sel_d = SEL_FF;
    if (!bus.cpu_we_in) begin
      if (cpu_is_vram && !vram_lock)     cpu_sel_d = SEL_VRAM;
      else if (cpu_is_oam && !oam_lock)  cpu_sel_d = SEL_OAM;
    end
  end

  always_comb begin
    bus.vram_addr_out  = 13'h0;
    bus.vram_we_out    = 1'b0;
    bus.vram_wdata_out = 8'h00;
    if (ppu_vram_go) begin
      bus.vram_addr_out = bus.ppu_vram_addr_in;
    end else if (cpu_vram_go) begin
      bus.vram_addr_out  = bus.cpu_addr_in[12:0];
      bus.vram_we_out    = bus.cpu_we_in;
      bus.vram_wdata_out = bus.cpu_we_in ? bus.cpu_wdata_in : 8'h00;
    end
  end

  always_comb begin
    bus.oam_addr_out  = 8'h00;
    bus.oam_we_out    = 1'b0;
    bus.oam_wdata_out = 8'h00;
    if (dma_wr) begin
      bus.oam_addr_out  = dma_k_q;
      bus.oam_we_out    = 1'b1;
      bus.oam_wdata_out = bus.dma_rd_data_in;
    end else if (ppu_oam_go) begin
      bus.oam_addr_out = bus.ppu_oam_addr_in;
    end else if (cpu_oam_go) begin
      bus.oam_addr_out  = bus.cpu_addr_in[7:0];
      bus.oam_we_out    = bus.cpu_we_in;
      bus.oam_wdata_out = bus.cpu_we_in ? bus.cpu_wdata_in : 8'h00;
    end
  end

  // p1: array data returns; p2: ack with captured read data
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1_q       <= 1'b0;
      sel_p1_q       <= SEL_FF;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= 8'h00;
      ppu_vram_vld_q <= 1'b0;
      ppu_oam_vld_q  <= 1'b0;
    end else begin
      vld_p1_q       <= cpu_accept;
      sel_p1_q       <= cpu_sel_d;
      cpu_ack_q      <= vld_p1_q;
      cpu_rdata_q    <= vld_p1_q ? cpu_read_mux(sel_p1_q, bus.vram_rdata_in, bus.oam_rdata_in)
                                 : 8'h00;
      ppu_vram_vld_q <= ppu_vram_go;
      ppu_oam_vld_q  <= ppu_oam_go;
    end
  end

  // Each byte: READ, WRITE, then WAIT pads the slot out to DMA_PERIOD cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dma_state_q   <= DMA_IDLE;
      dma_active_q  <= 1'b0;
      dma_rd_req_q  <= 1'b0;
      dma_rd_addr_q <= 16'h0000;
      dma_k_q       <= 8'h00;
      dma_wait_q    <= 8'h00;
    end else if (bus.dma_start_in) begin
      dma_state_q   <= DMA_READ;
      dma_src_q     <= echo_map(bus.dma_src_in);
      dma_active_q  <= 1'b1;
      dma_rd_req_q  <= 1'b1;
      dma_rd_addr_q <= {echo_map(bus.dma_src_in), 8'h00};
      dma_k_q       <= 8'h00;
    end else begin
      case (dma_state_q)
        DMA_READ: begin
          dma_state_q   <= DMA_WRITE;
          dma_rd_req_q  <= 1'b0;
          dma_rd_addr_q <= 16'h0000;
        end
        DMA_WRITE: begin
          dma_state_q <= DMA_WAIT;
          dma_wait_q  <= 8'h00;
        end
        DMA_WAIT: begin
          if (dma_wait_q == 8'(DMA_PERIOD - 3)) begin
            if (dma_k_q == 8'(OAM_BYTES - 1)) begin
              dma_state_q  <= DMA_IDLE;
              dma_active_q <= 1'b0;
            end else begin
              dma_state_q   <= DMA_READ;
              dma_k_q       <= dma_k_q + 8'd1;
              dma_rd_req_q  <= 1'b1;
              dma_rd_addr_q <= {dma_src_q, dma_k_q + 8'd1};
            end
          end else begin
            dma_wait_q <= dma_wait_q + 8'd1;
          end
        end
        default: dma_state_q <= DMA_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata_out      = cpu_rdata_q;
  assign bus.cpu_ack_out        = cpu_ack_q;
  assign bus.ppu_vram_valid_out = ppu_vram_vld_q;
  assign bus.ppu_vram_data_out  = ppu_vram_vld_q ? bus.vram_rdata_in : 8'h00;
  assign bus.ppu_oam_valid_out  = ppu_oam_vld_q;
  assign bus.ppu_oam_data_out   = ppu_oam_vld_q ? bus.oam_rdata_in : 8'h00;
  assign bus.dma_active_out     = dma_active_q;
  assign bus.dma_rd_req_out     = dma_rd_req_q;
  assign bus.dma_rd_addr_out    = dma_rd_addr_q;
endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Scoreboard bench for vram_oam_arbiter: stimulus queues expected responses,
// a forked monitor pops them as the DUT presents ack/valid outputs.
module tb_vram_oam_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_oam_arbiter_if bus();
  vram_oam_arbiter #(.DMA_PERIOD(4), .OAM_BYTES(160)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  typedef struct { int cyc; logic [7:0] data; } exp_t;
  exp_t cpu_q[$];
  exp_t pv_q[$];
  exp_t po_q[$];
  exp_t e;
  logic [15:0] rd_log[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int act_cnt = 0;
  int wr_cnt  = 0;
  int we_any  = 0;
  logic [7:0] last_wr = 8'h00;

  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  always @(posedge clk) begin
    if (bus.vram_we_out) vram_mem[bus.vram_addr_out] <= bus.vram_wdata_out;
    bus.vram_rdata_in <= vram_mem[bus.vram_addr_out];
    if (bus.oam_we_out) oam_mem[bus.oam_addr_out] <= bus.oam_wdata_out;
    bus.oam_rdata_in <= oam_mem[bus.oam_addr_out];
    bus.dma_rd_data_in <= bus.dma_rd_req_out ? (bus.dma_rd_addr_out[7:0] ^ 8'hA5) : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_acc(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] exp);
    exp_t x;
    tick();
    bus.cpu_req_in = 1'b1; bus.cpu_we_in = we; bus.cpu_addr_in = a; bus.cpu_wdata_in = wd;
    x.cyc = cyc + 2; x.data = exp;
    cpu_q.push_back(x);
    tick();
    bus.cpu_req_in = 1'b0; bus.cpu_we_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ppu_vram(input logic [12:0] a, input logic [7:0] exp);
    exp_t x;
    tick();
    bus.ppu_vram_req_in = 1'b1; bus.ppu_vram_addr_in = a;
    x.cyc = cyc + 1; x.data = exp;
    pv_q.push_back(x);
    tick();
    bus.ppu_vram_req_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic ppu_oam(input logic [7:0] a, input logic [7:0] exp, input logic expect_vld);
    exp_t x;
    tick();
    bus.ppu_oam_req_in = 1'b1; bus.ppu_oam_addr_in = a;
    x.cyc = cyc + 1; x.data = exp;
    if (expect_vld) po_q.push_back(x);
    tick();
    bus.ppu_oam_req_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic dma_go(input logic [7:0] src);
    tick();
    bus.dma_start_in = 1'b1; bus.dma_src_in = src;
    tick();
    bus.dma_start_in = 1'b0;
  endtask

  task automatic wait_writes(input int base, input int target, input string name);
    int t = 0;
    while ((wr_cnt - base) < target && t < 1000) begin
      tick();
      t++;
    end
    check(name, wr_cnt - base, target);
  endtask

  task automatic check_rd_seq(input int base, input logic [15:0] start, input string name);
    int errs = 0;
    for (int k = 0; k < 160; k++) begin
      if (base + k >= rd_log.size()) errs++;
      else if (rd_log[base + k] !== start + 16'(k)) errs++;
    end
    check(name, errs, 0);
  endtask

  initial begin
    int w0, r0, a0, errs;
    bus.ppu_mode_in = 2'd0; bus.lcd_en_in = 1'b1;
    bus.cpu_req_in = 1'b0; bus.cpu_we_in = 1'b0; bus.cpu_addr_in = 16'h0; bus.cpu_wdata_in = 8'h0;
    bus.ppu_vram_req_in = 1'b0; bus.ppu_vram_addr_in = 13'h0;
    bus.ppu_oam_req_in = 1'b0; bus.ppu_oam_addr_in = 8'h0;
    bus.dma_start_in = 1'b0; bus.dma_src_in = 8'h0;

    fork
      forever begin
        @(negedge clk);
        if (bus.cpu_ack_out) begin
          if (cpu_q.size() == 0) check("cpu_ack_unexpected", {31'b0, bus.cpu_ack_out}, 0);
          else begin
            e = cpu_q.pop_front();
            check("cpu_ack_cycle", cyc, e.cyc);
            check("cpu_rdata", {24'b0, bus.cpu_rdata_out}, {24'b0, e.data});
          end
        end
        if (bus.ppu_vram_valid_out) begin
          if (pv_q.size() == 0) check("ppu_vram_unexpected", {31'b0, bus.ppu_vram_valid_out}, 0);
          else begin
            e = pv_q.pop_front();
            check("ppu_vram_cycle", cyc, e.cyc);
            check("ppu_vram_data", {24'b0, bus.ppu_vram_data_out}, {24'b0, e.data});
          end
        end
        if (bus.ppu_oam_valid_out) begin
          if (po_q.size() == 0) check("ppu_oam_unexpected", {31'b0, bus.ppu_oam_valid_out}, 0);
          else begin
            e = po_q.pop_front();
            check("ppu_oam_cycle", cyc, e.cyc);
            check("ppu_oam_data", {24'b0, bus.ppu_oam_data_out}, {24'b0, e.data});
          end
        end
        if (bus.oam_we_out) we_any++;
        if (bus.oam_we_out && bus.dma_active_out) begin
          wr_cnt++;
          last_wr = bus.oam_addr_out;
          check("dma_wdata", {24'b0, bus.oam_wdata_out}, {24'b0, bus.oam_addr_out ^ 8'hA5});
        end
        if (bus.dma_active_out) act_cnt++;
        if (bus.dma_rd_req_out) rd_log.push_back(bus.dma_rd_addr_out);
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu", {23'b0, bus.cpu_ack_out, bus.cpu_rdata_out}, 0);
    check("rst_dma", {15'b0, bus.dma_active_out, bus.dma_rd_req_out, bus.dma_rd_addr_out}, 0);
    check("rst_ppu", {14'b0, bus.ppu_vram_valid_out, bus.ppu_oam_valid_out,
                      bus.ppu_vram_data_out, bus.ppu_oam_data_out}, 0);
    check("rst_arrays", {30'b0, bus.vram_we_out, bus.oam_we_out}, 0);
    tick();
    rst = 1'b0;

    // HBlank: CPU owns VRAM and OAM
    cpu_acc(1'b1, 16'h8123, 8'h5A, 8'hFF);
    cpu_acc(1'b0, 16'h8123, 8'h00, 8'h5A);
    cpu_acc(1'b1, 16'h8000, 8'h77, 8'hFF);
    cpu_acc(1'b1, 16'hFE10, 8'h3C, 8'hFF);

    // Draw: VRAM locked for CPU, served to PPU
    bus.ppu_mode_in = 2'd3;
    cpu_acc(1'b0, 16'h8123, 8'h00, 8'hFF);
    cpu_acc(1'b1, 16'h8000, 8'h11, 8'hFF);
    ppu_vram(13'h0123, 8'h5A);
    bus.ppu_mode_in = 2'd0;
    cpu_acc(1'b0, 16'h8000, 8'h00, 8'h77);

    // OAMScan: OAM locked; LCD off hands it back to the CPU
    bus.ppu_mode_in = 2'd2;
    cpu_acc(1'b0, 16'hFE10, 8'h00, 8'hFF);
    ppu_oam(8'h10, 8'h3C, 1'b1);
    bus.lcd_en_in = 1'b0;
    cpu_acc(1'b0, 16'hFE10, 8'h00, 8'h3C);
    ppu_oam(8'h10, 8'h00, 1'b0);
    ppu_vram(13'h0123, 8'h00);
    void'(pv_q.pop_back());
    bus.lcd_en_in = 1'b1;
    bus.ppu_mode_in = 2'd0;

    // full DMA from 0xC100
    w0 = wr_cnt; r0 = rd_log.size(); a0 = act_cnt;
    dma_go(8'hC1);
    cpu_acc(1'b0, 16'hFE10, 8'h00, 8'hFF);
    repeat (700) tick();
    check("dma_active_cycles", act_cnt - a0, 640);
    check("dma_writes", wr_cnt - w0, 160);
    check("dma_last_addr", {24'b0, last_wr}, 159);
    check("dma_reads", rd_log.size() - r0, 160);
    check_rd_seq(r0, 16'hC100, "dma_rd_addr_seq");
    errs = 0;
    for (int k = 0; k < 160; k++) if (oam_mem[k] !== (8'(k) ^ 8'hA5)) errs++;
    check("oam_contents", errs, 0);
    check("dma_idle_after", {31'b0, bus.dma_active_out}, 0);

    // restart at byte 50 with echo source 0xE2 -> 0xC2
    w0 = wr_cnt;
    dma_go(8'hC1);
    wait_writes(w0, 50, "restart_reach_byte50");
    w0 = wr_cnt; r0 = rd_log.size();
    dma_go(8'hE2);
    repeat (700) tick();
    check("restart_writes", wr_cnt - w0, 160);
    check("restart_reads", rd_log.size() - r0, 160);
    check_rd_seq(r0, 16'hC200, "restart_rd_addr_seq");
    check("restart_last_addr", {24'b0, last_wr}, 159);
    check("restart_idle_after", {31'b0, bus.dma_active_out}, 0);

    // reset at byte 30 aborts the DMA
    w0 = wr_cnt;
    dma_go(8'hC3);
    wait_writes(w0, 30, "abort_reach_byte30");
    w0 = we_any;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_active_low", {31'b0, bus.dma_active_out}, 0);
    repeat (100) tick();
    check("abort_no_oam_we", we_any - w0, 0);

    // unmapped address, with a second request while outstanding
    tick();
    bus.cpu_req_in = 1'b1; bus.cpu_we_in = 1'b0; bus.cpu_addr_in = 16'hFF80;
    e.cyc = cyc + 2; e.data = 8'hFF;
    cpu_q.push_back(e);
    @(negedge clk);
    check("ff80_no_strobes", {bus.vram_we_out, bus.oam_we_out, 9'b0, bus.vram_addr_out,
                              bus.oam_addr_out}, 0);
    tick();
    tick();
    bus.cpu_req_in = 1'b0;
    repeat (6) tick();

    check("cpu_q_drained", cpu_q.size(), 0);
    check("ppu_vram_q_drained", pv_q.size(), 0);
    check("ppu_oam_q_drained", po_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
